// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the pixel-advance enable going into the generator
// and the per-pixel timing outputs going to the windowing stage and DAC pins.
// Handshake: there is no back-pressure. The consumer drives ce, and the
// generator advances exactly one pixel on every clk edge that samples ce=1.
// All outputs are registered and describe the same pixel (vga_x, vga_y).
interface vga_timing_gen_if;
   logic       ce;
   logic [9:0] vga_x;
   logic [9:0] vga_y;
   logic       hsync;
   logic       vsync;
   logic       video_active;
   logic       frame_start;
   logic       line_start;

   modport master (
      input  ce,
      output vga_x, vga_y, hsync, vsync, video_active, frame_start, line_start
   );

   modport slave (
      output ce,
      input  vga_x, vga_y, hsync, vsync, video_active, frame_start, line_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator (default 1024x768@60, 65 MHz pixel).
// Two wrap counters walk the raster. Every flag register is loaded from the
// next-count value in the same edge as the counters, so all outputs line up
// with the coordinates they describe.
module vga_timing_gen #(
   parameter int H_VIS    = 1024,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 160,
   parameter int V_VIS    = 768,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 29,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   vga_timing_gen_if.master  bus
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   // 11-bit counters; the outputs carry only the low 10 bits.
   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS_L    = 11'(H_VIS);
   localparam logic [10:0] V_VIS_L    = 11'(V_VIS);
   localparam logic [10:0] HS_START   = 11'(H_VIS + H_FP);
   localparam logic [10:0] HS_END     = 11'(H_VIS + H_FP + H_SYNC);
   localparam logic [10:0] VS_START   = 11'(V_VIS + V_FP);
   localparam logic [10:0] VS_END     = 11'(V_VIS + V_FP + V_SYNC);

   logic [10:0] r_h;
   logic [10:0] r_v;
   logic        r_hsync;
   logic        r_vsync;
   logic        r_video_active;
   logic        r_frame_start;
   logic        r_line_start;

   logic [10:0] w_h_next;
   logic [10:0] w_v_next;
   logic        w_h_wrap;
   logic        w_hs_on;
   logic        w_vs_on;
   logic        w_active;
   logic        w_unused_bits;

   // Next raster position and the timing flags belonging to that position.
   always_comb begin
      w_h_wrap = (r_h == H_LAST);
      w_h_next = w_h_wrap ? 11'd0 : r_h + 11'd1;
      w_v_next = r_v;
      if (w_h_wrap) begin
         w_v_next = (r_v == V_LAST) ? 11'd0 : r_v + 11'd1;
      end
      w_hs_on  = (w_h_next >= HS_START) && (w_h_next < HS_END);
      w_vs_on  = (w_v_next >= VS_START) && (w_v_next < VS_END);
      w_active = (w_h_next < H_VIS_L) && (w_v_next < V_VIS_L);
   end

   // Counters and flags: reset parks on the last blanking pixel of the frame,
   // ce=1 advances one pixel, ce=0 holds everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_h            <= H_LAST;
         r_v            <= V_LAST;
         r_hsync        <= ~SYNC_POL;
         r_vsync        <= ~SYNC_POL;
         r_video_active <= 1'b0;
         r_frame_start  <= 1'b0;
         r_line_start   <= 1'b0;
      end else if (bus.ce) begin
         r_h            <= w_h_next;
         r_v            <= w_v_next;
         r_hsync        <= w_hs_on ? SYNC_POL : ~SYNC_POL;
         r_vsync        <= w_vs_on ? SYNC_POL : ~SYNC_POL;
         r_video_active <= w_active;
         r_frame_start  <= (w_h_next == 11'd0) && (w_v_next == 11'd0);
         r_line_start   <= (w_h_next == 11'd0);
      end
   end

   assign bus.vga_x        = r_h[9:0];
   assign bus.vga_y        = r_v[9:0];
   assign bus.hsync        = r_hsync;
   assign bus.vsync        = r_vsync;
   assign bus.video_active = r_video_active;
   assign bus.frame_start  = r_frame_start;
   assign bus.line_start   = r_line_start;

   // Counter MSBs only feed the compares, never the 10-bit outputs.
   assign w_unused_bits = r_h[10] ^ r_v[10];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 1024x768 instance plus two small
// rasters (negative and positive sync) that reach frame wrap and vsync quickly.
// The reference model tracks a linear pixel index per raster and derives
// x, y and all flags from it with division and range tests.
module tb_vga_timing_gen;

  localparam int W = 75;

  logic clk;
  logic rst_n;
  logic ce;

  vga_timing_gen_if bus_full ();
  vga_timing_gen_if bus_s0 ();
  vga_timing_gen_if bus_s1 ();

  assign bus_full.ce = ce;
  assign bus_s0.ce   = ce;
  assign bus_s1.ce   = ce;

  vga_timing_gen dut_full (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_full)
  );

  vga_timing_gen #(
    .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
  ) dut_s0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s0)
  );

  vga_timing_gen #(
    .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
  ) dut_s1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and scoreboard ----------------
  int checks;
  int failures;
  logic [W-1:0] exp_q[$];
  int pm[3];

  // monitor-observed measurements on the full-size raster
  int edge_n;
  int ls_last;
  int ls_period;
  logic ls_prev;
  int fs_run;
  int fs_last_len;

  // ---------------- reference model ----------------
  function automatic int geom(input int k, input int sel);
    int g[9];
    if (k == 0) g = '{1024, 24, 136, 160, 768, 3, 6, 29, 0};
    else        g = '{16, 2, 3, 4, 6, 1, 2, 2, (k == 2) ? 1 : 0};
    return g[sel];
  endfunction

  function automatic int frame_total(input int k);
    int ht;
    int vt;
    ht = geom(k, 0) + geom(k, 1) + geom(k, 2) + geom(k, 3);
    vt = geom(k, 4) + geom(k, 5) + geom(k, 6) + geom(k, 7);
    return ht * vt;
  endfunction

  function automatic logic [24:0] model_pix(input int k, input int p);
    int hv, hf, hs, vv, vf, vs, ht, x, y;
    logic pol, hs_on, vs_on;
    hv = geom(k, 0); hf = geom(k, 1); hs = geom(k, 2);
    vv = geom(k, 4); vf = geom(k, 5); vs = geom(k, 6);
    pol = (geom(k, 8) != 0);
    ht = hv + hf + hs + geom(k, 3);
    x = p % ht;
    y = p / ht;
    hs_on = (x >= hv + hf) && (x < hv + hf + hs);
    vs_on = (y >= vv + vf) && (y < vv + vf + vs);
    return {10'(x), 10'(y), hs_on ? pol : ~pol, vs_on ? pol : ~pol,
            (x < hv) && (y < vv), (x == 0) && (y == 0), x == 0};
  endfunction

  function automatic logic in_both_syncs(input int p);
    int x;
    int y;
    x = p % 25;
    y = p / 25;
    return (x >= 18) && (x < 21) && (y >= 7) && (y < 9);
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic ce_v, input logic rst_v);
    @(negedge clk);
    ce    = ce_v;
    rst_n = rst_v;
    for (int k = 0; k < 3; k++) begin
      if (!rst_v) pm[k] = frame_total(k) - 1;
      else if (ce_v) pm[k] = (pm[k] + 1) % frame_total(k);
    end
    exp_q.push_back({model_pix(0, pm[0]), model_pix(1, pm[1]), model_pix(2, pm[2])});
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    logic [24:0] a[3];
    string nm[3];
    nm = '{"pix_full", "pix_small_neg", "pix_small_pos"};
    edge_n = 0; ls_last = -1; ls_period = 0; ls_prev = 1'b0;
    fs_run = 0; fs_last_len = 0;
    forever begin
      @(posedge clk);
      #1;
      edge_n++;
      a[0] = {bus_full.vga_x, bus_full.vga_y, bus_full.hsync, bus_full.vsync,
              bus_full.video_active, bus_full.frame_start, bus_full.line_start};
      a[1] = {bus_s0.vga_x, bus_s0.vga_y, bus_s0.hsync, bus_s0.vsync,
              bus_s0.video_active, bus_s0.frame_start, bus_s0.line_start};
      a[2] = {bus_s1.vga_x, bus_s1.vga_y, bus_s1.hsync, bus_s1.vsync,
              bus_s1.video_active, bus_s1.frame_start, bus_s1.line_start};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < 3; k++) begin
          logic [24:0] ek;
          ek = e[74 - 25*k -: 25];
          checks++;
          if (a[k] !== ek) begin
            failures++;
            $display("FAIL %s t=%0t actual x=%0d y=%0d hs/vs/act/fs/ls=%b required x=%0d y=%0d hs/vs/act/fs/ls=%b",
                     nm[k], $time, a[k][24:15], a[k][14:5], a[k][4:0],
                     ek[24:15], ek[14:5], ek[4:0]);
          end
        end
      end
      if (bus_full.line_start && !ls_prev) begin
        if (ls_last >= 0) ls_period = edge_n - ls_last;
        ls_last = edge_n;
      end
      ls_prev = bus_full.line_start;
      if (bus_full.frame_start) fs_run++;
      else if (fs_run > 0) begin
        fs_last_len = fs_run;
        fs_run = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic found;
    checks = 0;
    failures = 0;
    ce = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) pm[k] = frame_total(k) - 1;

    // reset with ce held high, then release: first edge lands on (0,0)
    repeat (3) step(1'b1, 1'b0);

    // continuous ce: three full lines, many small frames
    repeat (3 * 1344 + 20) step(1'b1, 1'b1);
    check_int("line_period_cont", ls_period, 1344);

    // reset, then ce one-of-three
    repeat (2) step(1'b0, 1'b0);
    for (int i = 0; i < 3 * 1344; i++) begin
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
    end
    check_int("line_period_1of3", ls_period, 4032);
    check_int("frame_start_len_1of3", fs_last_len, 3);

    // random ce with occasional reset
    repeat (6000) begin
      logic ce_v;
      logic rst_v;
      ce_v  = ($urandom_range(0, 3) != 0);
      rst_v = ($urandom_range(0, 999) != 0);
      step(ce_v, rst_v);
    end

    // one-clock reset pulse while both syncs of the small rasters are active
    step(1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      step(1'b1, 1'b1);
      if (in_both_syncs(pm[1])) found = 1'b1;
    end
    check_int("reached_both_syncs", int'(found), 1);
    step(1'b1, 1'b0);
    repeat (40) step(1'b1, 1'b1);

    @(posedge clk);
    #2;
    check_int("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
